sc_level_progress_counter: RTL
==============================

Name: sc_level_progress_counter

Overview:
- Datapath/counter end of the level-control handshake. Owns the current-level register, the in-level progress counter, the elapsed-tick counter and the T0 tick prescaler.
- Outputs feed the level state machine's CurrentLevel, LvlProgressCount and T0 inputs.
- Consumes that machine's active-low strobes: LevelFinished, FinishedGame, upCount and ProgressUpCount.
- Sits between the game-start button logic and the level state machine.

Parameters:
- LEVEL_WIDTH, 3, width of the current-level output (values 0..4).
- PROGRESS_TARGET, 20, progress count at which a level is complete; progress saturates here.
- PRESCALER_WIDTH, 26, width of the T0 prescaler counter.
- T0_PERIOD_L1, 25000000, T0 period in clocks at level 1 (must be >= 2).
- T0_PERIOD_L2, 12500000, T0 period in clocks at level 2 (must be >= 2).
- T0_PERIOD_L3, 6250000, T0 period in clocks at level 3 (must be >= 2).

Ports:
- SC_LEVEL_STATEMACHINE_CLOCK_50  in  1  system clock, 50 MHz.
- SC_LEVEL_STATEMACHINE_RESET_InHigh  in  1  reset, asynchronous, active-high.
- Start_InLow  in  1  start-game request, active low, synchronous.
- LevelFinished_InLow  in  1  level-complete strobe from the level state machine.
- FinishedGame_InLow  in  1  game-over indication from the level state machine.
- UpCount_InLow  in  1  elapsed-tick increment strobe.
- ProgressUpCount_InLow  in  1  progress increment strobe.
- CurrentLevel_Out  out  LEVEL_WIDTH  current level (0 = no game, 1..3 = playing, 4 = end).
- LvlProgressCount_Out  out  5  in-level progress count.
- ElapsedCount_Out  out  8  ticks counted in the current level.
- T0_OutLow  out  1  one-cycle active-low timing tick.
- Playing_Out  out  1  high while in state PLAY.

Behaviour:
- Reset values: all outputs and state registers take these values immediately on reset assertion, including mid-operation.
  - state = IDLE, CurrentLevel_Out = 0, LvlProgressCount_Out = 0, ElapsedCount_Out = 0.
  - T0_OutLow = 1, Playing_Out = 0, prescaler = 0.
- All other updates occur on the rising clock edge. All outputs are registered.
- States: IDLE, PLAY, ADVANCE, DONE.
- IDLE:
  - All counters held at 0.
  - Start_InLow == 0 -> level <= 1, prescaler <= 0, go to PLAY.
- PLAY:
  - Period P is selected by the current level: T0_PERIOD_L1, T0_PERIOD_L2 or T0_PERIOD_L3.
  - Prescaler counts up each clock. When prescaler == P-1, it wraps to 0 and T0_OutLow = 0 in the next cycle, for exactly one cycle. Otherwise T0_OutLow = 1.
  - ProgressUpCount_InLow == 0 -> progress + 1, saturating at PROGRESS_TARGET (never exceeds it).
  - UpCount_InLow == 0 -> elapsed + 1, saturating at 255.
  - LevelFinished_InLow == 0 with level 1 or 2:
    - level + 1; progress, elapsed and prescaler cleared; no T0 tick issued for this cycle.
    - go to ADVANCE.
  - LevelFinished_InLow == 0 with level 3: level <= 4, progress and elapsed cleared, go to DONE.
  - FinishedGame_InLow == 0 -> level <= 4, go to DONE.
- ADVANCE:
  - Prescaler frozen at 0, T0_OutLow = 1, all increment strobes ignored.
  - Leave when LevelFinished_InLow == 1 -> PLAY. This guarantees exactly one level increment per level-finish assertion, however long the strobe is held.
- DONE:
  - Level held at 4, T0_OutLow = 1, counters held, all inputs ignored.
  - Exited only by reset.
- Simultaneous events in PLAY:
  - LevelFinished and ProgressUpCount together: level advance wins, progress ends at 0.
  - FinishedGame and LevelFinished together: go to DONE.
  - Prescaler terminal count in the same cycle as a level finish: tick suppressed.
- A period change takes effect from prescaler 0 after each advance.

Test Plan (periods overridden to L1 = 8, L2 = 4, L3 = 2; PROGRESS_TARGET = 20):
- Reset then Start_InLow low for 1 cycle -> CurrentLevel_Out = 1 and Playing_Out = 1 next cycle. First T0_OutLow low pulse 8 clocks later, repeating every 8 clocks, each exactly 1 cycle wide.
- 25 single-cycle ProgressUpCount_InLow pulses at level 1 -> LvlProgressCount_Out = 20, holds at 20. 300 UpCount_InLow pulses -> ElapsedCount_Out = 255.
- LevelFinished_InLow held low for 5 cycles at level 1 -> CurrentLevel_Out = 2 (not 3), progress = 0, elapsed = 0, no T0 pulse during ADVANCE. After release, T0 period = 4 clocks.
- LevelFinished_InLow and ProgressUpCount_InLow low in the same cycle at level 2, progress = 19 -> level = 3, progress = 0.
- LevelFinished_InLow low at level 3 -> CurrentLevel_Out = 4, Playing_Out = 0, T0_OutLow stays 1. Start_InLow pulses are ignored.
- Reset asserted mid-PLAY at level 2, progress = 7 -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/sc_level_progress_counter.sv
// sc_level_progress_counter
// Datapath/counter end of the level-control handshake: owns the current level,
// the in-level progress count, the elapsed-tick count and the T0 prescaler.
// All strobe inputs are active low; all outputs are registered.

module sc_level_progress_counter #(
  parameter int unsigned LEVEL_WIDTH     = 3,
  parameter int unsigned PROGRESS_TARGET = 20,
  parameter int unsigned PRESCALER_WIDTH = 26,
  parameter int unsigned T0_PERIOD_L1    = 25000000,
  parameter int unsigned T0_PERIOD_L2    = 12500000,
  parameter int unsigned T0_PERIOD_L3    = 6250000
) (
  input  logic                   SC_LEVEL_STATEMACHINE_CLOCK_50,
  input  logic                   SC_LEVEL_STATEMACHINE_RESET_InHigh,
  input  logic                   Start_InLow,
  input  logic                   LevelFinished_InLow,
  input  logic                   FinishedGame_InLow,
  input  logic                   UpCount_InLow,
  input  logic                   ProgressUpCount_InLow,
  output logic [LEVEL_WIDTH-1:0] CurrentLevel_Out,
  output logic [4:0]             LvlProgressCount_Out,
  output logic [7:0]             ElapsedCount_Out,
  output logic                   T0_OutLow,
  output logic                   Playing_Out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    ADVANCE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [LEVEL_WIDTH-1:0]     LEVEL_ZERO   = '0;
  localparam logic [LEVEL_WIDTH-1:0]     LEVEL_ONE    = LEVEL_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0]     LEVEL_TWO    = LEVEL_WIDTH'(2);
  localparam logic [LEVEL_WIDTH-1:0]     LEVEL_THREE  = LEVEL_WIDTH'(3);
  localparam logic [LEVEL_WIDTH-1:0]     LEVEL_END    = LEVEL_WIDTH'(4);
  localparam logic [LEVEL_WIDTH-1:0]     LEVEL_STEP   = LEVEL_WIDTH'(1);
  localparam logic [4:0]                 PROGRESS_MAX = 5'(PROGRESS_TARGET);
  localparam logic [PRESCALER_WIDTH-1:0] PRESC_STEP   = PRESCALER_WIDTH'(1);
  localparam logic [PRESCALER_WIDTH-1:0] LAST_L1      = PRESCALER_WIDTH'(T0_PERIOD_L1 - 1);
  localparam logic [PRESCALER_WIDTH-1:0] LAST_L2      = PRESCALER_WIDTH'(T0_PERIOD_L2 - 1);
  localparam logic [PRESCALER_WIDTH-1:0] LAST_L3      = PRESCALER_WIDTH'(T0_PERIOD_L3 - 1);

  state_t                     state;
  logic [PRESCALER_WIDTH-1:0] prescaler;
  logic [PRESCALER_WIDTH-1:0] prescalerLast;
  logic                       prescalerWrap;
  logic                       startReq;
  logic                       levelFinish;
  logic                       gameFinish;
  logic                       upCount;
  logic                       progressUp;

  assign startReq    = ~Start_InLow;
  assign levelFinish = ~LevelFinished_InLow;
  assign gameFinish  = ~FinishedGame_InLow;
  assign upCount     = ~UpCount_InLow;
  assign progressUp  = ~ProgressUpCount_InLow;

  // Terminal prescaler value for the T0 period of the current level.
  always_comb begin
    prescalerLast = LAST_L1;
    case (CurrentLevel_Out)
      LEVEL_TWO:   prescalerLast = LAST_L2;
      LEVEL_THREE: prescalerLast = LAST_L3;
      default:     prescalerLast = LAST_L1;
    endcase
    prescalerWrap = (prescaler == prescalerLast);
  end

  // Level state machine with registered counters and outputs.
  always_ff @(posedge SC_LEVEL_STATEMACHINE_CLOCK_50 or posedge SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
    if (SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
      state                <= IDLE;
      CurrentLevel_Out     <= LEVEL_ZERO;
      LvlProgressCount_Out <= '0;
      ElapsedCount_Out     <= '0;
      T0_OutLow            <= 1'b1;
      Playing_Out          <= 1'b0;
      prescaler            <= '0;
    end else begin
      case (state)
        IDLE: begin
          LvlProgressCount_Out <= '0;
          ElapsedCount_Out     <= '0;
          prescaler            <= '0;
          T0_OutLow            <= 1'b1;
          Playing_Out          <= 1'b0;
          if (startReq) begin
            CurrentLevel_Out <= LEVEL_ONE;
            state            <= PLAY;
            Playing_Out      <= 1'b1;
          end
        end

        PLAY: begin
          if (levelFinish || gameFinish) begin
            // A finish in the same cycle as a terminal count swallows the tick.
            T0_OutLow   <= 1'b1;
            prescaler   <= '0;
            Playing_Out <= 1'b0;
            if (levelFinish) begin
              LvlProgressCount_Out <= '0;
              ElapsedCount_Out     <= '0;
            end
            if (gameFinish || CurrentLevel_Out == LEVEL_THREE) begin
              CurrentLevel_Out <= LEVEL_END;
              state            <= DONE;
            end else begin
              CurrentLevel_Out <= CurrentLevel_Out + LEVEL_STEP;
              state            <= ADVANCE;
            end
          end else begin
            T0_OutLow   <= ~prescalerWrap;
            prescaler   <= prescalerWrap ? '0 : prescaler + PRESC_STEP;
            Playing_Out <= 1'b1;
            if (progressUp && LvlProgressCount_Out < PROGRESS_MAX)
              LvlProgressCount_Out <= LvlProgressCount_Out + 5'd1;
            if (upCount && ElapsedCount_Out != 8'hFF)
              ElapsedCount_Out <= ElapsedCount_Out + 8'd1;
          end
        end

        ADVANCE: begin
          // Wait for strobe release so one held finish yields one level step.
          prescaler   <= '0;
          T0_OutLow   <= 1'b1;
          Playing_Out <= 1'b0;
          if (!levelFinish) begin
            state       <= PLAY;
            Playing_Out <= 1'b1;
          end
        end

        DONE: begin
          CurrentLevel_Out <= LEVEL_END;
          T0_OutLow        <= 1'b1;
          Playing_Out      <= 1'b0;
          prescaler        <= '0;
        end

        default: begin
          state       <= IDLE;
          T0_OutLow   <= 1'b1;
          Playing_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule
